tx_lane_striper: RTL and testbench

//  TX-side counterpart of the RX lane-strip stage. Accepts a packed byte stream (data + K flags) with

---
 rtl/tx_lane_striper.sv | 108 ++++++++++
 tb/tb_tx_lane_striper.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_lane_striper.sv
// tx_lane_striper: buffers a 16-byte/beat stream and stripes it round-robin across active PIPE lanes
module tx_lane_striper #(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   GEN,
  input  logic [4:0]   LANESNUMBER,
  input  logic [127:0] in_data,
  input  logic [15:0]  in_k,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] out_data,
  output logic [63:0]  out_k,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic [5:0]   PIPEWIDTH,
  output logic         cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [639:0] buf_d;
  logic [79:0]  buf_k;
  logic [6:0]   cnt, n_r, pop, rem;
  logic [4:0]   lanes_r;
  logic [2:0]   lg_r, lg_in;
  logic [5:0]   pw_in;
  logic         legal, acc, load, done;
  logic [511:0] w_d;
  logic [63:0]  w_k;
  logic [3:0]   s;
  logic [1:0]   j;
  always_comb begin
    pw_in = GEN == 3'd1 ? 6'(GEN1_PIPEWIDTH) : GEN == 3'd2 ? 6'(GEN2_PIPEWIDTH) :
            GEN == 3'd3 ? 6'(GEN3_PIPEWIDTH) : GEN == 3'd4 ? 6'(GEN4_PIPEWIDTH) :
            GEN == 3'd5 ? 6'(GEN5_PIPEWIDTH) : 6'd0;
    lg_in = LANESNUMBER == 5'd1 ? 3'd0 : LANESNUMBER == 5'd2 ? 3'd1 :
            LANESNUMBER == 5'd4 ? 3'd2 : LANESNUMBER == 5'd8 ? 3'd3 : 3'd4;
    legal = GEN >= 3'd1 && GEN <= 3'd5 && LANESNUMBER inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
    in_ready = (state == RUN || (state == IDLE && legal)) && cnt <= 7'd64;
    cfg_err = state == IDLE && in_valid && !legal;
    acc = in_valid && in_ready;
    load = cnt != 7'd0 && (cnt >= n_r || state == FLUSH) && (!out_valid || out_ready);
    pop = load ? (cnt < n_r ? cnt : n_r) : 7'd0;
    rem = cnt - pop;
    done = out_valid && out_last && out_ready;
    state_nx = (state == IDLE && acc) ? (in_last ? FLUSH : RUN) :
               (state == RUN && acc && in_last) ? FLUSH :
               (state == FLUSH && done) ? IDLE : state;
  end
  // Bytes at and above cnt are always zero, so the short final word pads itself.
  always_comb begin
    w_d = '0;
    w_k = '0;
    s = '0;
    j = '0;
    for (int b = 0; b < 64; b++) begin
      if (7'(b) < n_r) begin
        s = 4'(5'd16 - lanes_r + (5'(b) & (lanes_r - 5'd1)));
        j = 2'(b >> lg_r);
        w_d[{s, j, 3'b000} +: 8] = buf_d[b*8 +: 8];
        w_k[{s, j}] = buf_k[b];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      buf_d <= '0;
      buf_k <= '0;
      out_data <= '0;
      out_k <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      PIPEWIDTH <= '0;
      lanes_r <= '0;
      lg_r <= '0;
      n_r <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt + (acc ? 7'd16 : 7'd0) - pop;
      buf_d <= (buf_d >> {pop, 3'b000}) | (acc ? {512'b0, in_data} << {rem, 3'b000} : 640'b0);
      buf_k <= (buf_k >> pop) | (acc ? {64'b0, in_k} << rem : 80'b0);
      if (state == IDLE && acc) begin
        PIPEWIDTH <= pw_in;
        lanes_r <= LANESNUMBER;
        lg_r <= lg_in;
        n_r <= 7'(11'(LANESNUMBER) * 11'(pw_in) / 11'd8);
      end
      if (load) begin
        out_data <= w_d;
        out_k <= w_k;
        out_valid <= 1'b1;
        out_last <= state == FLUSH && cnt <= n_r;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tx_lane_striper.sv
// tb_tx_lane_striper: directed and random bursts checked against a byte-queue striping model
module tb_tx_lane_striper;
  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   GEN;
  logic [4:0]   LANESNUMBER;
  logic [127:0] in_data;
  logic [15:0]  in_k;
  logic         in_valid, in_last, in_ready;
  logic [511:0] out_data;
  logic [63:0]  out_k;
  logic         out_valid, out_last, out_ready;
  logic [5:0]   PIPEWIDTH;
  logic         cfg_err;
  int total = 0;
  int bad = 0;
  logic [7:0]   bd[$];
  logic         bk[$];
  logic [511:0] exp_d[$];
  logic [63:0]  exp_k[$];
  logic         exp_l[$];
  logic [511:0] first_d;
  logic [63:0]  first_k;
  int nwords;
  logic saw_block;

  tx_lane_striper dut (
    .clk(clk), .reset(reset), .GEN(GEN), .LANESNUMBER(LANESNUMBER),
    .in_data(in_data), .in_k(in_k), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_k(out_k), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .PIPEWIDTH(PIPEWIDTH), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int pw_of(input int g);
    return g == 2 ? 16 : g == 3 ? 32 : 8;
  endfunction

  function automatic void build_words(input int pw, input int lanes);
    int n, tot;
    n = lanes * pw / 8;
    tot = bd.size();
    for (int st = 0; st < tot; st += n) begin
      logic [511:0] d;
      logic [63:0] k;
      d = '0;
      k = '0;
      for (int b = 0; b < n; b++) begin
        if (st + b < tot) begin
          int sl, sy;
          sl = 16 - lanes + b % lanes;
          sy = b / lanes;
          d[sl*32 + sy*8 +: 8] = bd[st + b];
          k[sl*4 + sy] = bk[st + b];
        end
      end
      exp_d.push_back(d);
      exp_k.push_back(k);
      exp_l.push_back(st + n >= tot);
    end
  endfunction

  // rmode 0: always ready, 1: random ready plus cfg churn, 2: 20-cycle stall
  task automatic run_burst(input int g, input int lanes, input int nb, input int rmode, input bit seqd);
    logic [127:0] beat_d[16];
    logic [15:0]  beat_k[16];
    logic [511:0] prev_d;
    logic prev_v, prev_r, pwc, fl;
    int bi, cyc;
    bd.delete(); bk.delete();
    for (int i = 0; i < nb; i++) begin
      for (int b = 0; b < 16; b++) begin
        beat_d[i][b*8 +: 8] = seqd ? 8'(i*16 + b) : 8'($urandom);
        beat_k[i][b] = seqd ? (b == 0) : 1'($urandom);
        bd.push_back(beat_d[i][b*8 +: 8]);
        bk.push_back(beat_k[i][b]);
      end
    end
    build_words(pw_of(g), lanes);
    GEN = 3'(g);
    LANESNUMBER = 5'(lanes);
    bi = 0; cyc = 0; nwords = 0; saw_block = 0;
    prev_v = 0; prev_r = 0; prev_d = '0; pwc = 0; fl = 0;
    while ((bi < nb || exp_d.size() > 0) && cyc < 3000) begin
      in_valid = bi < nb;
      in_data = bi < nb ? beat_d[bi] : '0;
      in_k = bi < nb ? beat_k[bi] : '0;
      in_last = bi == nb - 1;
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom) : !(cyc >= 3 && cyc < 23);
      if (rmode == 1 && bi > 0) begin
        GEN = 3'($urandom);
        LANESNUMBER = 5'($urandom);
      end
      @(negedge clk);
      if (bi > 0 && !pwc) begin
        chk("pipewidth", 512'(PIPEWIDTH), 512'(pw_of(g)));
        pwc = 1;
      end
      if (fl) begin
        chk("flush_in_ready", 512'(in_ready), 512'(0));
        fl = 0;
      end
      if (prev_v && !prev_r) begin
        chk("hold_valid", 512'(out_valid), 512'(1));
        chk("hold_data", out_data, prev_d);
      end
      if (in_valid && !in_ready && bi > 0) saw_block = 1;
      if (out_valid && out_ready) begin
        if (exp_d.size() == 0) chk("extra_word", 512'(1), 512'(0));
        else begin
          if (nwords == 0) begin
            first_d = out_data;
            first_k = out_k;
          end
          chk("word_data", out_data, exp_d.pop_front());
          chk("word_k", 512'(out_k), 512'(exp_k.pop_front()));
          chk("word_last", 512'(out_last), 512'(exp_l.pop_front()));
        end
        nwords++;
      end
      if (in_valid && in_ready) begin
        if (bi == nb - 1) fl = 1;
        bi++;
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 3000) chk("timeout", 512'(cyc), 512'(0));
    in_valid = 0;
    in_last = 0;
    out_ready = 1;
  endtask

  initial begin
    reset = 1; GEN = 3'd1; LANESNUMBER = 5'd16;
    in_data = '0; in_k = '0; in_valid = 0; in_last = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_out_data", out_data, 512'(0));
    chk("rst_pipewidth", 512'(PIPEWIDTH), 512'(0));
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("idle_in_ready", 512'(in_ready), 512'(1));
    @(posedge clk); #1;

    run_burst(1, 16, 1, 0, 1);
    chk("t1_words", 512'(nwords), 512'(1));
    chk("t1_lane0", 512'(first_d[7:0]), 512'(8'h00));
    chk("t1_lane15", 512'(first_d[487:480]), 512'(8'h0F));

    run_burst(3, 4, 1, 0, 1);
    chk("t2_lane0", 512'(first_d[415:384]), 512'(32'h0C080400));
    chk("t2_low", 512'(first_d[383:0]), 512'(0));

    run_burst(5, 1, 1, 0, 1);
    chk("t3_words", 512'(nwords), 512'(16));
    chk("t3_byte0", 512'(first_d[487:480]), 512'(8'h00));
    chk("t3_k60", 512'(first_k[60]), 512'(1));

    run_burst(2, 16, 3, 0, 1);
    chk("t4_words", 512'(nwords), 512'(2));

    run_burst(1, 4, 10, 2, 0);
    chk("t5_backpressure", 512'(saw_block), 512'(1));

    GEN = 3'd1; LANESNUMBER = 5'd3; in_valid = 1;
    @(negedge clk);
    chk("t6_cfg_err", 512'(cfg_err), 512'(1));
    chk("t6_in_ready", 512'(in_ready), 512'(0));
    @(posedge clk); #1;
    GEN = 3'd6; LANESNUMBER = 5'd4;
    @(negedge clk);
    chk("t6_gen_err", 512'(cfg_err), 512'(1));
    @(posedge clk); #1;
    in_valid = 0; GEN = 3'd2; LANESNUMBER = 5'd8;
    @(negedge clk);
    chk("t6_no_err", 512'(cfg_err), 512'(0));
    chk("t6_no_word", 512'(out_valid), 512'(0));
    @(posedge clk); #1;

    GEN = 3'd5; LANESNUMBER = 5'd1; in_data = {8{16'hA55A}}; in_k = '1;
    in_valid = 1; in_last = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    chk("t6_stalled_valid", 512'(out_valid), 512'(1));
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("t6_rst_valid", 512'(out_valid), 512'(0));
    chk("t6_rst_last", 512'(out_last), 512'(0));
    chk("t6_rst_idle", 512'(in_ready), 512'(1));
    @(posedge clk); #1;
    out_ready = 1;
    exp_d.delete(); exp_k.delete(); exp_l.delete();
    run_burst(4, 8, 2, 0, 0);
    chk("t6_after_rst_words", 512'(nwords), 512'(4));

    for (int r = 0; r < 12; r++)
      run_burst($urandom_range(1, 5), 1 << $urandom_range(0, 4), $urandom_range(1, 6), 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
